// File: rtl/poly_voice_engine.sv
// rtl/poly_voice_engine.sv - time-multiplexed polyphonic oscillator and mixer, one sample per tick
module poly_voice_engine #(
    parameter int VOICES     = 4,
    parameter int PHASE_W    = 24,
    parameter int SAMPLE_DIV = 1000,
    localparam int AW        = (VOICES > 1) ? $clog2(VOICES) : 1,
    localparam int ACC_W     = 16 + $clog2(VOICES) + 1,
    localparam int CNT_W     = $clog2(SAMPLE_DIV)
) (
    input  logic               clk48m,
    input  logic               rst_n,
    input  logic               voice_we,
    input  logic [AW-1:0]      voice_addr,
    input  logic [PHASE_W-1:0] voice_inc,
    input  logic [1:0]         voice_wave,
    input  logic [7:0]         voice_gain,
    input  logic               voice_phase_rst,
    output logic [15:0]        sample,
    output logic               sample_valid,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

    state_t                   state;
    logic [CNT_W-1:0]         tick_cnt;
    logic                     tick;
    logic [AW-1:0]            idx;
    logic signed [ACC_W-1:0]  acc;

    logic [PHASE_W-1:0]       phase [VOICES];
    logic [PHASE_W-1:0]       inc   [VOICES];
    logic [1:0]               wave  [VOICES];
    logic [7:0]               gain  [VOICES];

    logic                     addr_ok;
    logic                     last_voice;
    logic [PHASE_W-1:0]       next_phase;
    logic [15:0]              p;
    logic [14:0]              tri_half;
    logic signed [15:0]       w;
    logic signed [8:0]        g9;
    logic signed [24:0]       prod;
    logic signed [16:0]       term;
    logic signed [ACC_W-1:0]  acc_next;
    logic [15:0]              sat_val;

    assign tick       = (tick_cnt == CNT_W'(SAMPLE_DIV - 1));
    assign addr_ok    = voice_we && (32'(voice_addr) < 32'(VOICES));
    assign last_voice = (32'(idx) == 32'(VOICES - 1));

    // Datapath for the voice selected by idx; uses pre-write config so a same-cycle write does not affect it
    assign next_phase = phase[idx] + inc[idx];
    assign p          = next_phase[PHASE_W-1 -: 16];
    assign tri_half   = p[15] ? ~p[14:0] : p[14:0];
    assign g9         = $signed({1'b0, gain[idx]});
    assign prod       = w * g9;
    assign term       = prod[24:8];
    assign acc_next   = acc + ACC_W'(term);

    // Waveform shaping from the top 16 phase bits; the -32768 offset is a flip of the MSB
    always_comb begin
        w = '0;
        case (wave[idx])
            2'b01:   w = p[15] ? 16'sh8001 : 16'sh7fff;
            2'b10:   w = $signed({~p[15], p[14:0]});
            2'b11:   w = $signed({~tri_half[14], tri_half[13:0], 1'b0});
            default: w = '0;
        endcase
    end

    // Clamp the wide accumulator into the signed 16-bit output range
    always_comb begin
        sat_val = acc[15:0];
        if (acc > SAT_HI)
            sat_val = 16'h7fff;
        else if (acc < SAT_LO)
            sat_val = 16'h8000;
    end

    // Free-running sample-period counter; tick marks its last count
    always_ff @(posedge clk48m or negedge rst_n) begin
        if (!rst_n)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CNT_W'(1);
    end

    // Sequencer: walk all voices once per tick, then publish the saturated mix
    always_ff @(posedge clk48m or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            acc          <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= RUN;
                        idx   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (last_voice)
                        state <= DONE;
                    else
                        idx <= idx + AW'(1);
                end
                DONE: begin
                    sample       <= sat_val;
                    sample_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Voice state: phase advances on its RUN visit; config writes land immediately, phase reset wins
    always_ff @(posedge clk48m or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VOICES; v++) begin
                phase[v] <= '0;
                inc[v]   <= '0;
                wave[v]  <= '0;
                gain[v]  <= '0;
            end
        end else begin
            if (state == RUN)
                phase[idx] <= next_phase;
            if (addr_ok) begin
                inc[voice_addr]  <= voice_inc;
                wave[voice_addr] <= voice_wave;
                gain[voice_addr] <= voice_gain;
                if (voice_phase_rst)
                    phase[voice_addr] <= '0;
            end
        end
    end

endmodule
